// File: rtl/reset_seq_pkg.sv
// Shared types and default timing constants for the reset sequencer.
package reset_seq_pkg;

   typedef enum logic [2:0] {
      S_PLL_RESET,
      S_WAIT_LOCK,
      S_SDRAM_INIT,
      S_RUN,
      S_CPU_RESET
   } state_e;

   localparam int DEF_PLL_RST_CYCLES      = 16;
   localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
   localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
   localparam int DEF_DEBOUNCE_CYCLES     = 4096;

   // Largest of four values; sizes the shared counter width.
   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module bit_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Capture the asynchronous input through two flops to settle metastability.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so both stages sample their inputs from
      // before the edge; blocking would collapse the chain into a single flop.
      if (!reset_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Power-up / recovery reset sequencer. Runs on the board reference clock so it
// keeps working while the PLL is in reset. Releases SDRAM reset before the
// CPU/system reset, re-runs everything on lock loss, and resets only the CPU
// domain on a debounced push-button request.
// sys_reset is asynchronous to PLL-derived clock domains; every consumer must
// re-synchronize it locally.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
   parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
   parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
   parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pll_locked,
   input  logic reset_req,
   input  logic sdram_init_done,
   output logic pll_rst,
   output logic sdram_reset,
   output logic sys_reset,
   output logic running
);

   localparam int CNT_W = $clog2(max4(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                      LOCK_TIMEOUT_CYCLES, DEBOUNCE_CYCLES)) + 1;

   localparam logic [CNT_W-1:0] PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Saturating increment: counters hold at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   logic locked_s;
   logic req_s;

   state_e           state_q,   state_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;      // PLL reset length / lock timeout
   logic [CNT_W-1:0] stable_q,  stable_d;   // consecutive cycles of lock
   logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
   logic             req_deb_q, req_deb_d;

   logic pll_rst_q;
   logic sdram_reset_q;
   logic sys_reset_q;
   logic running_q;

   bit_sync u_sync_lock (
      .clk     (clk),
      .reset_n (reset_n),
      .d_i     (pll_locked),
      .q_o     (locked_s)
   );

   bit_sync u_sync_req (
      .clk     (clk),
      .reset_n (reset_n),
      .d_i     (reset_req),
      .q_o     (req_s)
   );

   // Debouncer: accept a new request level only after it has differed from the
   // accepted level for DEBOUNCE_CYCLES consecutive cycles.
   always_comb begin
      req_deb_d = req_deb_q;
      deb_cnt_d = '0;
      if (req_s != req_deb_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            req_deb_d = req_s;
         end else begin
            deb_cnt_d = sat_inc(deb_cnt_q);
         end
      end
   end

   // Sequencer next-state and counter decode.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      state_d  = state_q;
      cnt_d    = '0;
      stable_d = '0;

      unique case (state_q)
         S_PLL_RESET: begin
            if (cnt_q == PLL_LAST) begin
               state_d = S_WAIT_LOCK;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end

         S_WAIT_LOCK: begin
            if (locked_s && (stable_q == STABLE_LAST)) begin
               state_d = S_SDRAM_INIT;
            end else if (cnt_q == TIMEOUT_LAST) begin
               state_d = S_PLL_RESET;
            end else begin
               cnt_d    = sat_inc(cnt_q);
               stable_d = locked_s ? sat_inc(stable_q) : '0;
            end
         end

         S_SDRAM_INIT: begin
            if (!locked_s) begin
               state_d = S_PLL_RESET;
            end else if (sdram_init_done) begin
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            // Lock loss outranks the button.
            if (!locked_s) begin
               state_d = S_PLL_RESET;
            end else if (req_deb_q) begin
               state_d = S_CPU_RESET;
            end
         end

         S_CPU_RESET: begin
            if (!locked_s) begin
               state_d = S_PLL_RESET;
            end else if (!req_deb_q) begin
               state_d = S_RUN;
            end
         end

         default: state_d = S_PLL_RESET;
      endcase
   end

   // State, counters and debouncer registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= S_PLL_RESET;
         cnt_q     <= '0;
         stable_q  <= '0;
         deb_cnt_q <= '0;
         req_deb_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         stable_q  <= stable_d;
         deb_cnt_q <= deb_cnt_d;
         req_deb_q <= req_deb_d;
      end
   end

   // Glitch-free registered outputs decoded from the next state.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pll_rst_q     <= 1'b1;
         sdram_reset_q <= 1'b1;
         sys_reset_q   <= 1'b1;
         running_q     <= 1'b0;
      end else begin
         pll_rst_q     <= (state_d == S_PLL_RESET);
         sdram_reset_q <= (state_d == S_PLL_RESET) || (state_d == S_WAIT_LOCK);
         sys_reset_q   <= (state_d != S_RUN);
         running_q     <= (state_d == S_RUN);
      end
   end

   assign pll_rst     = pll_rst_q;
   assign sdram_reset = sdram_reset_q;
   assign sys_reset   = sys_reset_q;
   assign running     = running_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer. The stimulus process pushes the
// expected output vector for chosen cycles; a monitor on the falling edge pops
// and compares when that cycle arrives.
module tb_reset_sequencer;

   logic clk = 1'b0;
   logic reset_n;
   logic pll_locked;
   logic reset_req;
   logic sdram_init_done;
   logic pll_rst;
   logic sdram_reset;
   logic sys_reset;
   logic running;
   logic [3:0] obs;

   // Output vector {pll_rst, sdram_reset, sys_reset, running}.
   localparam logic [3:0] O_PLLRST = 4'b1110;
   localparam logic [3:0] O_WAIT   = 4'b0110;
   localparam logic [3:0] O_HOLD   = 4'b0010;  // S_SDRAM_INIT or S_CPU_RESET
   localparam logic [3:0] O_RUN    = 4'b0001;

   typedef struct {
      int         cyc;
      logic [3:0] v;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   exp_t e_mon;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   reset_sequencer #(
      .PLL_RST_CYCLES      (4),
      .LOCK_STABLE_CYCLES  (8),
      .LOCK_TIMEOUT_CYCLES (64),
      .DEBOUNCE_CYCLES     (4)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .pll_locked      (pll_locked),
      .reset_req       (reset_req),
      .sdram_init_done (sdram_init_done),
      .pll_rst         (pll_rst),
      .sdram_reset     (sdram_reset),
      .sys_reset       (sys_reset),
      .running         (running)
   );

   assign obs = {pll_rst, sdram_reset, sys_reset, running};

   always #5 clk = ~clk;

   // Cycle k is the interval following the k-th rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int c, input logic [3:0] got,
                        input logic [3:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s cycle %0d: got pll/sdram/sys/run=%b want %b", name, c, got, want);
      end
   endtask

   task automatic expect_at(input int c, input logic [3:0] v, input string name);
      exp_t e;
      e.cyc  = c;
      e.v    = v;
      e.name = name;
      exp_q.push_back(e);
   endtask

   // Advance to just after rising edge c; inputs set here are sampled at c+1.
   task automatic go_to(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: compare every expectation due in the current cycle.
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         e_mon = exp_q.pop_front();
         if (e_mon.cyc != cyc) begin
            total++;
            bad++;
            $display("FAIL %s: due at cycle %0d, reached at cycle %0d", e_mon.name, e_mon.cyc, cyc);
         end else begin
            check(e_mon.name, cyc, obs, e_mon.v);
         end
      end
   end

   initial begin
      int b, b2, p, q, l, g, z, n;
      reset_n         = 1'b0;
      pll_locked      = 1'b0;
      reset_req       = 1'b0;
      sdram_init_done = 1'b0;

      // Clean power-up: lock at cycle 10, init done at cycle 40.
      b = 3;
      expect_at(2,      O_PLLRST, "reset_values");
      expect_at(b,      O_PLLRST, "pll_rst_first");
      expect_at(b + 3,  O_PLLRST, "pll_rst_last");
      expect_at(b + 4,  O_WAIT,   "pll_rst_fall");
      expect_at(b + 19, O_WAIT,   "still_wait_lock");
      expect_at(b + 20, O_HOLD,   "sdram_release");
      expect_at(b + 40, O_HOLD,   "sdram_init_hold");
      expect_at(b + 41, O_RUN,    "sys_release");
      expect_at(b + 50, O_RUN,    "run_steady");
      go_to(b);
      reset_n = 1'b1;
      go_to(b + 10);
      pll_locked = 1'b1;
      go_to(b + 40);
      sdram_init_done = 1'b1;
      go_to(b + 41);
      sdram_init_done = 1'b0;

      // Buttons in S_RUN: short pulse ignored, long pulse resets CPU only,
      // then lock loss during S_CPU_RESET re-runs the full sequence.
      b2 = b + 55;
      p  = b2 + 15;
      q  = p + 35;
      expect_at(b2 + 6,  O_RUN,    "short_pulse_a");
      expect_at(b2 + 10, O_RUN,    "short_pulse_b");
      expect_at(p + 6,   O_RUN,    "long_pulse_pre");
      expect_at(p + 7,   O_HOLD,   "cpu_reset_enter");
      expect_at(p + 26,  O_HOLD,   "cpu_reset_hold");
      expect_at(p + 27,  O_RUN,    "cpu_reset_exit");
      expect_at(q + 7,   O_HOLD,   "cpu_reset_again");
      expect_at(q + 12,  O_HOLD,   "cpu_reset_pre_loss");
      expect_at(q + 13,  O_PLLRST, "cpu_reset_lock_loss");
      expect_at(q + 16,  O_PLLRST, "reseq_pll_last");
      expect_at(q + 17,  O_WAIT,   "reseq_wait");
      expect_at(q + 29,  O_WAIT,   "reseq_wait_last");
      expect_at(q + 30,  O_HOLD,   "reseq_sdram_release");
      expect_at(q + 36,  O_RUN,    "reseq_run");
      go_to(b2);
      reset_req = 1'b1;
      go_to(b2 + 3);
      reset_req = 1'b0;
      go_to(p);
      reset_req = 1'b1;
      go_to(p + 20);
      reset_req = 1'b0;
      go_to(q);
      reset_req = 1'b1;
      go_to(q + 10);
      pll_locked = 1'b0;
      go_to(q + 14);
      reset_req = 1'b0;
      go_to(q + 20);
      pll_locked = 1'b1;
      go_to(q + 35);
      sdram_init_done = 1'b1;
      go_to(q + 36);
      sdram_init_done = 1'b0;

      // Lock loss in S_RUN, then a one-cycle lock glitch during S_WAIT_LOCK.
      l = q + 45;
      g = l + 10;
      expect_at(l + 2,  O_RUN,    "run_before_loss");
      expect_at(l + 3,  O_PLLRST, "run_lock_loss_3cyc");
      expect_at(l + 6,  O_PLLRST, "loss_pll_last");
      expect_at(l + 7,  O_WAIT,   "loss_wait");
      expect_at(g + 15, O_WAIT,   "glitch_restart");
      expect_at(g + 16, O_HOLD,   "glitch_sdram_release");
      expect_at(g + 20, O_HOLD,   "sdram_init_pre_reset");
      go_to(l);
      pll_locked = 1'b0;
      go_to(g);
      pll_locked = 1'b1;
      go_to(g + 5);
      pll_locked = 1'b0;
      go_to(g + 6);
      pll_locked = 1'b1;

      // reset_n pulsed for one cycle in S_SDRAM_INIT, lock held.
      z = g + 21;
      expect_at(z,      O_PLLRST, "mid_reset_values");
      expect_at(z + 3,  O_PLLRST, "mid_reset_pll_last");
      expect_at(z + 4,  O_WAIT,   "mid_reset_wait");
      expect_at(z + 11, O_WAIT,   "mid_reset_wait_last");
      expect_at(z + 12, O_HOLD,   "mid_reset_sdram_release");
      expect_at(z + 15, O_RUN,    "mid_reset_run");
      go_to(g + 20);
      reset_n = 1'b0;
      go_to(z);
      reset_n = 1'b1;
      go_to(z + 14);
      sdram_init_done = 1'b1;
      go_to(z + 15);
      sdram_init_done = 1'b0;

      // Never lock: 4-cycle pll_rst pulses every 68 cycles.
      n = z + 20;
      expect_at(n + 2,   O_RUN,    "never_pre");
      expect_at(n + 3,   O_PLLRST, "never_pulse0_first");
      expect_at(n + 6,   O_PLLRST, "never_pulse0_last");
      expect_at(n + 7,   O_WAIT,   "never_wait0");
      expect_at(n + 70,  O_WAIT,   "timeout_last_wait");
      expect_at(n + 71,  O_PLLRST, "timeout_pulse1_first");
      expect_at(n + 74,  O_PLLRST, "timeout_pulse1_last");
      expect_at(n + 75,  O_WAIT,   "timeout_wait1");
      expect_at(n + 100, O_WAIT,   "timeout_mid");
      expect_at(n + 138, O_WAIT,   "timeout_pre_pulse2");
      expect_at(n + 139, O_PLLRST, "timeout_pulse2");
      go_to(n);
      pll_locked = 1'b0;
      go_to(n + 142);

      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d expectations never compared", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
